// File: rtl/des_scomp_pipe.sv
// DES S-box substitution stage: run-time loadable 64x4 lane tables feeding a
// valid/ready pipeline, with a LOAD/RUN/DRAIN controller for table reloads.
module des_scomp_pipe #(
   parameter int unsigned NUM_SBOX    = 8,
   parameter int unsigned PIPE_STAGES = 1,
   parameter int unsigned SEL_W       = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [6*NUM_SBOX-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*NUM_SBOX-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  tbl_wr_en,
   input  logic [SEL_W-1:0]      tbl_wr_sel,
   input  logic [5:0]            tbl_wr_addr,
   input  logic [3:0]            tbl_wr_data,
   input  logic                  tbl_reload,
   output logic                  tbl_loaded,
   output logic                  tbl_wr_err
);

   localparam int unsigned OUT_W = 4 * NUM_SBOX;
   localparam int unsigned TOTAL = NUM_SBOX * 64;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);
   localparam int unsigned LAST  = PIPE_STAGES - 1;

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   loaded_q, loaded_d;
   logic [PIPE_STAGES-1:0] vld_q, vld_d;
   logic [OUT_W-1:0]       data_q [PIPE_STAGES];
   logic [OUT_W-1:0]       data_d [PIPE_STAGES];

   logic [3:0]             tbl_q [NUM_SBOX][64];
   logic [OUT_W-1:0]       lut_c;
   logic [5:0]             lane_addr_c;
   logic [3:0]             lane_ent_c;
   logic [PIPE_STAGES-1:0] free_c;
   logic                   room_c;
   logic                   sel_ok_c;
   logic                   wr_ok_c;
   logic                   in_fire_c;

   assign sel_ok_c  = 32'(tbl_wr_sel) < NUM_SBOX;
   assign in_ready  = (state_q == S_RUN) && free_c[0];
   assign in_fire_c = in_valid && in_ready;

   // Table storage is deliberately unreset; it must be reloaded after reset.
   always_ff @(posedge clk_in) begin
      if (wr_ok_c) tbl_q[tbl_wr_sel][tbl_wr_addr] <= tbl_wr_data;
   end

   // Lane lookup: row from bits 0/5, column from bits 1..4; entry MSB lands on out[4k].
   always_comb begin
      lut_c       = '0;
      lane_addr_c = '0;
      lane_ent_c  = '0;
      for (int k = 0; k < int'(NUM_SBOX); k++) begin
         lane_addr_c = {in_data[6*k], in_data[6*k+5], in_data[6*k+1],
                        in_data[6*k+2], in_data[6*k+3], in_data[6*k+4]};
         lane_ent_c  = tbl_q[k][lane_addr_c];
         lut_c[4*k +: 4] = {lane_ent_c[0], lane_ent_c[1], lane_ent_c[2], lane_ent_c[3]};
      end
   end

   // A stage may load when it, or any stage downstream of it, is empty or the sink is ready.
   always_comb begin
      free_c = '0;
      room_c = out_ready;
      for (int i = int'(LAST); i >= 0; i--) begin
         room_c    = room_c | ~vld_q[i];
         free_c[i] = room_c;
      end
   end

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (free_c[0]) begin
         vld_d[0] = in_fire_c;
         if (in_fire_c) data_d[0] = lut_c;
      end
      for (int i = 1; i < int'(PIPE_STAGES); i++) begin
         if (free_c[i]) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) data_d[i] = data_q[i-1];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      wr_ok_c = 1'b0;
      case (state_q)
         S_LOAD: begin
            wr_ok_c = tbl_wr_en && sel_ok_c;
            err_d   = tbl_wr_en && !sel_ok_c;
            if (cnt_q == CNT_W'(TOTAL)) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else if (wr_ok_c) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            err_d = tbl_wr_en;
            if (tbl_reload) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            err_d = tbl_wr_en;
            cnt_d = '0;
            if (vld_q == '0) state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
      loaded_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= S_LOAD;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         loaded_q <= 1'b0;
         vld_q    <= '0;
         for (int i = 0; i < int'(PIPE_STAGES); i++) data_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         loaded_q <= loaded_d;
         vld_q    <= vld_d;
         for (int i = 0; i < int'(PIPE_STAGES); i++) data_q[i] <= data_d[i];
      end
   end

   assign out_valid  = vld_q[LAST];
   assign out_data   = data_q[LAST];
   assign tbl_loaded = loaded_q;
   assign tbl_wr_err = err_q;

endmodule

// File: tb/tb_des_scomp_pipe.sv
// Bench for des_scomp_pipe: a 1-stage and a 3-stage instance share the table
// port; each has its own input/output handshake and expected-result queue.
module tb_des_scomp_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [47:0] in_data;
   logic        in_valid1, in_valid3;
   logic        in_ready1, in_ready3;
   logic [31:0] out_data1, out_data3;
   logic        out_valid1, out_valid3;
   logic        out_ready1, out_ready3;
   logic        or3_man, tog_en, tog_rdy;
   logic        tbl_wr_en;
   logic [2:0]  tbl_wr_sel;
   logic [5:0]  tbl_wr_addr;
   logic [3:0]  tbl_wr_data;
   logic        tbl_reload;
   logic        tbl_loaded1, tbl_loaded3;
   logic        tbl_wr_err1, tbl_wr_err3;

   int          n_checks = 0;
   int          n_errors = 0;
   int          tog_cnt  = 0;
   logic [31:0] q1[$];
   logic [31:0] q3[$];
   logic [3:0]  mdl [8][64];
   logic [255:0] des_s [8];

   always #5 clk = ~clk;

   assign out_ready3 = tog_en ? tog_rdy : or3_man;

   des_scomp_pipe #(.NUM_SBOX(8), .PIPE_STAGES(1)) dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .in_data(in_data), .in_valid(in_valid1),
      .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
      .out_ready(out_ready1), .tbl_wr_en(tbl_wr_en), .tbl_wr_sel(tbl_wr_sel),
      .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_reload(tbl_reload),
      .tbl_loaded(tbl_loaded1), .tbl_wr_err(tbl_wr_err1));

   des_scomp_pipe #(.NUM_SBOX(8), .PIPE_STAGES(3)) dut3 (
      .clk_in(clk), .rst_n_in(rst_n), .in_data(in_data), .in_valid(in_valid3),
      .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .tbl_wr_en(tbl_wr_en), .tbl_wr_sel(tbl_wr_sel),
      .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_reload(tbl_reload),
      .tbl_loaded(tbl_loaded3), .tbl_wr_err(tbl_wr_err3));

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [47:0] d);
      logic [31:0] r;
      logic [5:0]  s;
      logic [1:0]  row;
      logic [3:0]  col;
      logic [3:0]  e;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         s   = d[6*k +: 6];
         row = {s[0], s[5]};
         col = {s[1], s[2], s[3], s[4]};
         e   = mdl[k][{row, col}];
         for (int j = 0; j < 4; j++) r[4*k + j] = e[3 - j];
      end
      return r;
   endfunction

   // Output monitors: every valid cycle must present the queue head; pop on transfer.
   always @(negedge clk) begin
      if (rst_n && out_valid1) begin
         if (q1.size() == 0) check_eq("p1_extra_out", 32'(out_valid1), 32'd0);
         else begin
            check_eq("p1_data", out_data1, q1[0]);
            if (out_ready1) void'(q1.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid3) begin
         if (q3.size() == 0) check_eq("p3_extra_out", 32'(out_valid3), 32'd0);
         else begin
            check_eq("p3_data", out_data3, q3[0]);
            if (out_ready3) void'(q3.pop_front());
         end
      end
   end

   // Downstream ready pattern 1,0,0 repeating.
   always @(posedge clk) begin
      #1;
      tog_rdy = (tog_cnt == 0);
      tog_cnt = (tog_cnt + 1) % 3;
   end

   task automatic send(input int which, input logic [47:0] d, input logic [31:0] e);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      in_data = d;
      if (which == 1) in_valid1 = 1'b1; else in_valid3 = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = (which == 1) ? in_ready1 : in_ready3;
         if (acc) begin
            if (which == 1) q1.push_back(e); else q3.push_back(e);
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid1 = 1'b0;
      in_valid3 = 1'b0;
      check_eq("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic lat_check(input string tag, input int which, input int exp_n);
      int   n;
      logic v;
      n = 0;
      v = 1'b0;
      while (!v && n < 10) begin
         @(negedge clk);
         n++;
         v = (which == 1) ? out_valid1 : out_valid3;
      end
      check_eq(tag, 32'(n), 32'(exp_n));
   endtask

   task automatic load_tables(input int mode, input int count);
      int s, a;
      logic [3:0] v;
      for (int i = 0; i < count; i++) begin
         s = i / 64;
         a = i % 64;
         case (mode)
            0:       v = 4'(a);
            1:       v = des_s[s][255 - 4*a -: 4];
            default: v = 4'(a ^ (s * 5 + 3));
         endcase
         @(posedge clk); #1;
         tbl_wr_en   = 1'b1;
         tbl_wr_sel  = 3'(s);
         tbl_wr_addr = 6'(a);
         tbl_wr_data = v;
         mdl[s][a]   = v;
      end
      @(posedge clk); #1;
      tbl_wr_en = 1'b0;
   endtask

   task automatic wait_loaded(input string tag);
      int n;
      n = 0;
      while (!(tbl_loaded1 && tbl_loaded3) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'({tbl_loaded1, tbl_loaded3}), 32'd3);
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq(tag, 32'(q1.size() + q3.size()), 32'd0);
   endtask

   task automatic reload_pulse();
      @(posedge clk); #1;
      tbl_reload = 1'b1;
      @(posedge clk); #1;
      tbl_reload = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [47:0] d;
      des_s[0] = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      des_s[1] = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      des_s[2] = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      des_s[3] = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      des_s[4] = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      des_s[5] = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      des_s[6] = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      des_s[7] = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

      rst_n = 1'b0; in_data = '0; in_valid1 = 1'b0; in_valid3 = 1'b0;
      out_ready1 = 1'b1; or3_man = 1'b1; tog_en = 1'b0;
      tbl_wr_en = 1'b0; tbl_wr_sel = '0; tbl_wr_addr = '0; tbl_wr_data = '0; tbl_reload = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'({in_ready1, in_ready3}), 32'd0);
      check_eq("rst_out_valid", 32'({out_valid1, out_valid3}), 32'd0);
      check_eq("rst_out_data1", out_data1, 32'd0);
      check_eq("rst_out_data3", out_data3, 32'd0);
      check_eq("rst_loaded", 32'({tbl_loaded1, tbl_loaded3}), 32'd0);
      check_eq("rst_wr_err", 32'({tbl_wr_err1, tbl_wr_err3}), 32'd0);
      rst_n = 1'b1;

      // Identity-column tables, loaded-flag timing, 1-stage latency.
      load_tables(0, 512);
      @(negedge clk);
      check_eq("t1_loaded_early", 32'(tbl_loaded1), 32'd0);
      check_eq("t1_in_ready_load", 32'(in_ready1), 32'd0);
      @(negedge clk);
      check_eq("t1_loaded", 32'({tbl_loaded1, tbl_loaded3}), 32'd3);
      @(posedge clk); #1;
      send(1, 48'h000000000002, 32'h00000001);
      lat_check("t1_latency", 1, 1);
      wait_drain("t1_drain");

      // Standard DES tables.
      reload_pulse();
      load_tables(1, 512);
      wait_loaded("t2_loaded");
      send(1, 48'h000000000036, 32'hB234E5FA);
      send(3, 48'h000000000036, 32'hB234E5FA);
      wait_drain("t2_drain");

      // Write attempt in RUN is rejected and leaves the table untouched.
      @(posedge clk); #1;
      tbl_wr_en = 1'b1; tbl_wr_sel = 3'd0; tbl_wr_addr = 6'd0; tbl_wr_data = 4'h0;
      @(negedge clk);
      check_eq("t4_err_early", 32'(tbl_wr_err1), 32'd0);
      @(posedge clk); #1;
      tbl_wr_en = 1'b0;
      @(negedge clk);
      check_eq("t4_err_pulse", 32'({tbl_wr_err1, tbl_wr_err3}), 32'd3);
      check_eq("t4_still_loaded", 32'(tbl_loaded1), 32'd1);
      @(negedge clk);
      check_eq("t4_err_end", 32'(tbl_wr_err1), 32'd0);
      @(posedge clk); #1;
      send(1, 48'h000000000000, 32'hB234E5F7);
      send(1, 48'h000000000036, 32'hB234E5FA);
      wait_drain("t4_drain");

      // 3-stage: single-word latency, then a stream under 1,0,0 backpressure.
      d = {16'($urandom()), $urandom()};
      send(3, d, model(d));
      lat_check("t3_latency", 3, 3);
      wait_drain("t3_drain_a");
      tog_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d = {16'($urandom()), $urandom()};
         send(3, d, model(d));
      end
      wait_drain("t3_drain_b");
      tog_en = 1'b0;

      // Fill under backpressure, reload, drain, then load new tables.
      or3_man = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d = {16'($urandom()), $urandom()};
         send(3, d, model(d));
      end
      @(negedge clk);
      check_eq("t5_full_in_ready", 32'(in_ready3), 32'd0);
      check_eq("t5_full_valid", 32'(out_valid3), 32'd1);
      @(posedge clk); #1;
      tbl_reload = 1'b1;
      @(posedge clk); #1;
      tbl_reload = 1'b0;
      tbl_wr_en = 1'b1; tbl_wr_sel = 3'd1; tbl_wr_addr = 6'd5; tbl_wr_data = 4'h9;
      in_valid3 = 1'b1;
      @(negedge clk);
      check_eq("t5_drain_loaded", 32'(tbl_loaded3), 32'd0);
      check_eq("t5_drain_in_ready", 32'(in_ready3), 32'd0);
      @(posedge clk); #1;
      tbl_wr_en = 1'b0;
      @(negedge clk);
      check_eq("t5_drain_wr_err", 32'({tbl_wr_err1, tbl_wr_err3}), 32'd3);
      repeat (3) @(negedge clk);
      check_eq("t5_hold_in_ready", 32'(in_ready3), 32'd0);
      check_eq("t5_hold_valid", 32'(out_valid3), 32'd1);
      in_valid3 = 1'b0;
      @(posedge clk); #1;
      or3_man = 1'b1;
      wait_drain("t5_drain");
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("t5_load_loaded", 32'({tbl_loaded1, tbl_loaded3}), 32'd0);
      check_eq("t5_load_in_ready", 32'(in_ready3), 32'd0);
      @(posedge clk); #1;
      load_tables(2, 512);
      wait_loaded("t5_reloaded");
      for (int i = 0; i < 4; i++) begin
         d = {16'($urandom()), $urandom()};
         send(1, d, model(d));
         send(3, d, model(d));
      end
      wait_drain("t5_new_drain");

      // Asynchronous reset between clock edges while words are in flight.
      for (int i = 0; i < 4; i++) begin
         d = {16'($urandom()), $urandom()};
         send(3, d, model(d));
      end
      #3;
      check_eq("t6_pre_valid", 32'(out_valid3), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_valid", 32'({out_valid1, out_valid3}), 32'd0);
      check_eq("t6_rst_in_ready", 32'({in_ready1, in_ready3}), 32'd0);
      check_eq("t6_rst_loaded", 32'({tbl_loaded1, tbl_loaded3}), 32'd0);
      q1.delete();
      q3.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      load_tables(2, 100);
      in_valid1 = 1'b1;
      in_valid3 = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_eq("t6_partial_in_ready", 32'({in_ready1, in_ready3}), 32'd0);
      end
      check_eq("t6_partial_loaded", 32'({tbl_loaded1, tbl_loaded3}), 32'd0);
      in_valid1 = 1'b0;
      in_valid3 = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
